// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector: run-time loadable pattern, per-cycle overlap select,
// saturating match counter. Define SEQ_DET_MASK_EN to add a don't-care mask loaded with the pattern.
module seq_detector_param #(
    parameter int unsigned    LEN           = 4,
    parameter int unsigned    CNT_W         = 8,
    parameter logic [LEN-1:0] RESET_PATTERN = 4'b1011
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             w,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [LEN-1:0]   pat_in,
    input  logic             cnt_clr,
`ifdef SEQ_DET_MASK_EN
    input  logic [LEN-1:0]   mask_in,
`endif
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN-1:0]   pattern
);

    localparam int unsigned      FW       = $clog2(LEN + 1);
    localparam logic [FW-1:0]    FillFull = FW'(LEN);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    logic [LEN-1:0]   hist_q, hist_d;
    logic [LEN-1:0]   pattern_q, pattern_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [LEN-1:0]   hist_shift;
    logic [FW-1:0]    fill_inc;
    logic [LEN-1:0]   cmp_mask;
    logic             match;

`ifdef SEQ_DET_MASK_EN
    logic [LEN-1:0]   mask_q, mask_d;

    assign cmp_mask = mask_q;
    assign mask_d   = pat_load ? mask_in : mask_q;
`else
    assign cmp_mask = '1;
`endif

    always_comb begin
        hist_shift = {hist_q[LEN-2:0], w};
        fill_inc   = (fill_q == FillFull) ? fill_q : fill_q + FW'(1);
        // A load edge discards the sample, so it can never complete a match.
        match      = en && !pat_load && (fill_inc == FillFull) &&
                     (((hist_shift ^ pattern_q) & cmp_mask) == '0);

        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        if (pat_load) begin
            pattern_d = pat_in;
            hist_d    = '0;
            fill_d    = '0;
        end else if (en) begin
            hist_d = hist_shift;
            fill_d = (match && !overlap) ? '0 : fill_inc;
        end

        z_d = match;

        // Clear first, then the match on the same edge still counts.
        cnt_d = cnt_clr ? '0 : cnt_q;
        if (match && (cnt_d != CntMax)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= RESET_PATTERN;
            z_q       <= 1'b0;
            cnt_q     <= '0;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            z_q       <= z_d;
            cnt_q     <= cnt_d;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign pattern     = pattern_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param (LEN=4, CNT_W=8): vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_seq_detector_param;

    localparam int LEN = 4;

    logic       clk;
    logic       resetn;
    logic       en;
    logic       w;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       cnt_clr;
    logic [3:0] mask_in;
    logic       z;
    logic [7:0] match_count;
    logic [3:0] pattern;

    int checks;
    int failures;

    seq_detector_param dut (
        .clk         (clk),
        .resetn      (resetn),
        .en          (en),
        .w           (w),
        .overlap     (overlap),
        .pat_load    (pat_load),
        .pat_in      (pat_in),
        .cnt_clr     (cnt_clr),
`ifdef SEQ_DET_MASK_EN
        .mask_in     (mask_in),
`endif
        .z           (z),
        .match_count (match_count),
        .pattern     (pattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the bits received since the last reset/load/non-overlapping match.
    bit       m_bits[$];
    bit [3:0] m_pat;
    bit [3:0] m_mask;
    int       m_cnt;
    bit       m_z;

    task automatic model_reset();
        m_bits.delete();
        m_pat  = 4'b1011;
        m_mask = 4'b1111;
        m_cnt  = 0;
        m_z    = 1'b0;
    endtask

    task automatic model_edge();
        bit hit;
        hit = 1'b0;
        if (cnt_clr) m_cnt = 0;
        if (pat_load) begin
            m_pat  = pat_in;
            m_mask = mask_in;
            m_bits.delete();
        end else if (en) begin
            m_bits.push_back(w);
            if (m_bits.size() > LEN) void'(m_bits.pop_front());
            if (m_bits.size() == LEN) begin
                hit = 1'b1;
                // Oldest bit is compared against pattern bit LEN-1.
                for (int i = 0; i < LEN; i++) begin
                    if (m_mask[LEN-1-i] && (m_bits[i] != m_pat[LEN-1-i])) hit = 1'b0;
                end
            end
            if (hit && !overlap) m_bits.delete();
        end
        if (hit && m_cnt < 255) m_cnt++;
        m_z = hit;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_z"}, int'(z), int'(m_z));
        check({tag, "_cnt"}, int'(match_count), m_cnt);
        check({tag, "_pat"}, int'(pattern), int'(m_pat));
    endtask

    task automatic drive(input bit e, input bit b, input bit ov, input bit pl, input bit clr,
                         input bit [3:0] pin);
        en = e; w = b; overlap = ov; pat_load = pl; cnt_clr = clr; pat_in = pin;
    endtask

    typedef struct {
        bit       en, w, ov, pl, clr;
        bit [3:0] pin;
        bit       ez;
        int       ecnt;
        bit [3:0] epat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit e, input bit b, input bit ov, input bit pl, input bit clr,
                       input bit [3:0] pin, input bit ez, input int ecnt, input bit [3:0] epat);
        vec_t v;
        v.en = e; v.w = b; v.ov = ov; v.pl = pl; v.clr = clr; v.pin = pin;
        v.ez = ez; v.ecnt = ecnt; v.epat = epat;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        mask_in  = 4'b1111;
        drive(0, 0, 1, 0, 0, 4'b0000);
        model_reset();

        // Overlapping 1011011: hits after the 4th and 7th samples.
        add(1,1,1,0,0,4'h0, 0,0,4'b1011); add(1,0,1,0,0,4'h0, 0,0,4'b1011);
        add(1,1,1,0,0,4'h0, 0,0,4'b1011); add(1,1,1,0,0,4'h0, 1,1,4'b1011);
        add(1,0,1,0,0,4'h0, 0,1,4'b1011); add(1,1,1,0,0,4'h0, 0,1,4'b1011);
        add(1,1,1,0,0,4'h0, 1,2,4'b1011);
        // Reload clears history; cnt_clr zeroes the count; the en=1 sample is dropped.
        add(1,1,0,1,1,4'b1011, 0,0,4'b1011);
        // Same stream, non-overlapping: only one hit.
        add(1,1,0,0,0,4'h0, 0,0,4'b1011); add(1,0,0,0,0,4'h0, 0,0,4'b1011);
        add(1,1,0,0,0,4'h0, 0,0,4'b1011); add(1,1,0,0,0,4'h0, 1,1,4'b1011);
        add(1,0,0,0,0,4'h0, 0,1,4'b1011); add(1,1,0,0,0,4'h0, 0,1,4'b1011);
        add(1,1,0,0,0,4'h0, 0,1,4'b1011);
        add(1,1,1,1,1,4'b1011, 0,0,4'b1011);
        // 1,0,1 then a 3-cycle en=0 gap (w=1 must be ignored), then the completing 1.
        add(1,1,1,0,0,4'h0, 0,0,4'b1011); add(1,0,1,0,0,4'h0, 0,0,4'b1011);
        add(1,1,1,0,0,4'h0, 0,0,4'b1011); add(0,1,1,0,0,4'h0, 0,0,4'b1011);
        add(0,1,1,0,0,4'h0, 0,0,4'b1011); add(0,1,1,0,0,4'h0, 0,0,4'b1011);
        add(1,1,1,0,0,4'h0, 1,1,4'b1011);
        // Load 0000 alongside an en=1 zero sample; that sample must not count.
        add(1,0,1,1,0,4'b0000, 0,1,4'b0000);
        add(1,0,1,0,0,4'h0, 0,1,4'b0000); add(1,0,1,0,0,4'h0, 0,1,4'b0000);
        add(1,0,1,0,0,4'h0, 0,1,4'b0000); add(1,0,1,0,0,4'h0, 1,2,4'b0000);
        add(1,0,1,0,0,4'h0, 1,3,4'b0000); add(1,0,1,0,0,4'h0, 1,4,4'b0000);

        repeat (2) @(posedge clk);
        #1;
        check("reset_z", int'(z), 0);
        check("reset_cnt", int'(match_count), 0);
        check("reset_pat", int'(pattern), 4'b1011);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].w, vecs[i].ov, vecs[i].pl, vecs[i].clr, vecs[i].pin);
            clk_edge();
            check($sformatf("vec%0d_z", i), int'(z), int'(vecs[i].ez));
            check($sformatf("vec%0d_cnt", i), int'(match_count), vecs[i].ecnt);
            check($sformatf("vec%0d_pat", i), int'(pattern), int'(vecs[i].epat));
        end

        // Saturation: every further zero is a hit with pattern 0000 and overlap.
        drive(1, 0, 1, 0, 0, 4'h0);
        for (int i = 0; i < 251; i++) begin
            clk_edge();
            check_model("sat");
        end
        check("sat_reach", int'(match_count), 255);
        clk_edge();
        check("sat_hold", int'(match_count), 255);
        check("sat_hold_z", int'(z), 1);
        cnt_clr = 1'b1;
        clk_edge();
        check("clr_with_match", int'(match_count), 1);
        cnt_clr = 1'b0;

        // Asynchronous reset right after a hit, with a full history.
        drive(0, 0, 1, 1, 0, 4'b0111);
        clk_edge();
        check_model("ld0111");
        drive(1, 0, 1, 0, 0, 4'h0);
        clk_edge(); check_model("pre0");
        w = 1'b1; clk_edge(); check_model("pre1");
        clk_edge(); check_model("pre2");
        clk_edge(); check_model("pre3");
        check("pre_rst_hit", int'(z), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_z", int'(z), 0);
        check("async_rst_cnt", int'(match_count), 0);
        check("async_rst_pat", int'(pattern), 4'b1011);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        // A stale history would complete 1011 early here.
        for (int i = 0; i < 7; i++) begin
            w = (i == 0 || i == 4) ? 1'b0 : 1'b1;
            clk_edge();
            check_model($sformatf("post_rst%0d", i));
        end

`ifdef SEQ_DET_MASK_EN
        drive(0, 0, 1, 1, 0, 4'b1001);
        mask_in = 4'b1001;
        clk_edge();
        drive(1, 1, 1, 0, 0, 4'h0);
        repeat (4) begin
            clk_edge();
            check_model("mask");
        end
        check("mask_hit", int'(z), 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 9) < 7);
            w        = 1'($urandom);
            overlap  = ($urandom_range(0, 3) != 0);
            pat_load = ($urandom_range(0, 39) == 0);
            pat_in   = 4'($urandom);
            cnt_clr  = ($urandom_range(0, 49) == 0);
`ifdef SEQ_DET_MASK_EN
            mask_in  = 4'($urandom) | 4'($urandom);
`endif
            clk_edge();
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
